dram_port_arbiter: RTL and testbench
====================================

Name: dram_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the DRAM controller user interface.
- Typical requesters: port 0 = CPU instruction fetch, port 1 = CPU data or DMA.
- Serialises single-beat reads and writes. Converts each requester's req/ack handshake into the controller's one-cycle rd_en/wr_en pulse protocol. Returns read data to the winning port.
- Sits in the controller's ui clock domain, between the bus fabric and the controller.

Parameters:
- ADDR_WIDTH, 27, user-interface word address width.
- DATA_WIDTH, 128, data beat width.
- MASK_WIDTH, 16, byte mask width; a mask bit of 1 means the byte is NOT written.

Ports:
- clk  in  1  controller ui clock.
- rst_x  in  1  asynchronous active-low reset.
- i_p0_req, i_p1_req  in  1  request; held high with stable fields until ack.
- i_p0_we, i_p1_we  in  1  1 = write, 0 = read.
- i_p0_addr, i_p1_addr  in  ADDR_WIDTH  word address.
- i_p0_data, i_p1_data  in  DATA_WIDTH  write data.
- i_p0_mask, i_p1_mask  in  MASK_WIDTH  write byte mask.
- o_p0_ack, o_p1_ack  out  1  one-cycle completion pulse.
- o_rdata  out  DATA_WIDTH  read data; valid in the cycle the ack for a read is high.
- o_mem_rd_en, o_mem_wr_en  out  1  controller command pulses.
- o_mem_addr  out  ADDR_WIDTH  controller address.
- o_mem_data  out  DATA_WIDTH  controller write data.
- o_mem_mask  out  MASK_WIDTH  controller write mask.
- i_mem_ready  in  1  controller idle and ready.
- i_mem_calib  in  1  controller init_calib_complete.
- i_mem_data  in  DATA_WIDTH  controller read data.
- i_mem_data_valid  in  1  controller read data valid.
- o_busy  out  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered. On reset:
  - state = IDLE, all enables, acks and o_busy = 0.
  - o_rdata, o_mem_addr, o_mem_data and o_mem_mask = 0.
  - RR pointer last = 1, so port 0 wins first.
- Reset is async and may be asserted mid-transaction. It drops o_mem_rd_en/o_mem_wr_en immediately and does not ack the in-flight request.
- States: IDLE, ISSUE, WAIT_WR, WAIT_RD, ACK.
- IDLE:
  - Grant only when i_mem_calib = 1, i_mem_ready = 1 and at least one req is high.
  - Single req: grant that port. Both reqs: grant the port != last, then set last = granted port.
  - On grant, latch we/addr/data/mask into the o_mem_* registers, assert o_mem_wr_en or o_mem_rd_en, and go to ISSUE.
- ISSUE: exactly one cycle. Deassert the enable; go to WAIT_WR if the latched op is a write, else WAIT_RD. The command pulse is exactly one cycle wide.
- WAIT_WR:
  - Done on the first i_mem_ready = 1. The controller drops ready on the cycle after sampling the command, so ready = 0 in the first WAIT cycle.
  - Go to ACK with the granted port's ack set.
- WAIT_RD: on i_mem_data_valid = 1, capture i_mem_data into o_rdata, set the granted port's ack, and go to ACK.
- ACK: the ack is high for this single cycle; clear it and return to IDLE.
- Re-issue is blocked until i_mem_ready = 1 again, so back-to-back requests are never sent while the controller is busy.
- Latency, in cycles from the grant edge:
  - rd/wr_en is high in cycle +1.
  - A write acks 1 cycle after ready returns.
  - A read acks 1 cycle after data_valid.
  - Minimum turnaround between grants is 4 cycles.
- i_mem_calib low: no new grants; an in-flight transaction still completes.
- i_mem_data_valid outside WAIT_RD is ignored; o_rdata holds its last value.
- A req dropped before ack is a protocol violation. The latched transaction still completes and is acked.
- A req that stays high in the ack cycle is treated as a new request in the following IDLE cycle.
- There is no timeout: WAIT_RD or WAIT_WR waits indefinitely.
- Both acks are never high in the same cycle.

Test Plan:
1. Calibration gate: i_mem_calib = 0 for 50 cycles, p0 read req → no rd_en. Raise calib → rd_en is a 1-cycle pulse with addr = p0 addr.
2. Single write: p1 we = 1, addr = 0x0000123, data = 128'hA5…, mask = 16'h00FF → wr_en is 1 cycle with identical addr/data/mask. Controller model drops then raises ready → o_p1_ack is a 1-cycle pulse 1 cycle later.
3. Single read: p0 addr = 0x0000040. Model returns data_valid with 128'hDEADBEEF… 10 cycles later → o_rdata equals it and o_p0_ack pulses in the next cycle.
4. Contention: both ports request continuously for 6 transactions → grant order 0,1,0,1,0,1, never two pulses in flight, every grant waits for ready = 1.
5. Back-to-back on the same port: p0 holds req through the ack → second transaction issues only after ready is high. Exactly 2 acks for 2 transactions.
6. Reset mid-read: assert rst_x low in WAIT_RD → outputs return to reset values asynchronously, no ack. After release, the port 0 request wins first.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - two-port round-robin arbiter and sequencer for the DRAM controller user interface
//
// Ports:
//   clk, rst_x                  ui clock, asynchronous active-low reset
//   i_pN_req/we/addr/data/mask  requester N command, held until o_pN_ack
//   o_pN_ack                    one-cycle completion pulse for requester N
//   o_rdata                     read data, valid while a read ack is high
//   o_mem_rd_en/wr_en           one-cycle command pulses to the controller
//   o_mem_addr/data/mask        latched command fields to the controller
//   i_mem_ready/calib           controller idle / calibration complete
//   i_mem_data/data_valid       controller read return
//   o_busy                      high whenever a transaction is in progress
module dram_port_arbiter #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_x,
    input  logic                  i_p0_req,
    input  logic                  i_p0_we,
    input  logic [ADDR_WIDTH-1:0] i_p0_addr,
    input  logic [DATA_WIDTH-1:0] i_p0_data,
    input  logic [MASK_WIDTH-1:0] i_p0_mask,
    input  logic                  i_p1_req,
    input  logic                  i_p1_we,
    input  logic [ADDR_WIDTH-1:0] i_p1_addr,
    input  logic [DATA_WIDTH-1:0] i_p1_data,
    input  logic [MASK_WIDTH-1:0] i_p1_mask,
    output logic                  o_p0_ack,
    output logic                  o_p1_ack,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_mem_rd_en,
    output logic                  o_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    output logic [MASK_WIDTH-1:0] o_mem_mask,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_calib,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic                  i_mem_data_valid,
    output logic                  o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_WR,
        S_WAIT_RD,
        S_ACK
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_q, last_d;    // port granted most recently
    logic                    port_q, port_d;    // port owning the current transaction
    logic                    wr_op_q, wr_op_d;
    logic                    rd_en_q, rd_en_d;
    logic                    wr_en_q, wr_en_d;
    logic                    ack0_q, ack0_d;
    logic                    ack1_q, ack1_d;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [MASK_WIDTH-1:0]   mask_q, mask_d;

    // With both ports requesting, the port that did not win last time goes next.
    logic                    pick;
    logic                    can_grant;
    assign pick      = (i_p0_req && i_p1_req) ? ~last_q : i_p1_req;
    assign can_grant = i_mem_calib && i_mem_ready && (i_p0_req || i_p1_req);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        port_d  = port_q;
        wr_op_d = wr_op_q;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        case (state_q)
            S_IDLE: begin
                if (can_grant) begin
                    last_d  = pick;
                    port_d  = pick;
                    wr_op_d = pick ? i_p1_we   : i_p0_we;
                    addr_d  = pick ? i_p1_addr : i_p0_addr;
                    data_d  = pick ? i_p1_data : i_p0_data;
                    mask_d  = pick ? i_p1_mask : i_p0_mask;
                    wr_en_d = wr_op_d;
                    rd_en_d = ~wr_op_d;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = wr_op_q ? S_WAIT_WR : S_WAIT_RD;
            end
            S_WAIT_WR: begin
                // Ready is already low here; its return marks the write done.
                if (i_mem_ready) begin
                    ack0_d  = ~port_q;
                    ack1_d  = port_q;
                    state_d = S_ACK;
                end
            end
            S_WAIT_RD: begin
                if (i_mem_data_valid) begin
                    rdata_d = i_mem_data;
                    ack0_d  = ~port_q;
                    ack1_d  = port_q;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            wr_op_q <= 1'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            wr_op_q <= wr_op_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= (state_d != S_IDLE);
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

    assign o_p0_ack    = ack0_q;
    assign o_p1_ack    = ack1_q;
    assign o_rdata     = rdata_q;
    assign o_mem_rd_en = rd_en_q;
    assign o_mem_wr_en = wr_en_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_data  = data_q;
    assign o_mem_mask  = mask_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - self-checking bench for dram_port_arbiter
module tb_dram_port_arbiter;

    localparam int AW = 27;
    localparam int DW = 128;
    localparam int MW = 16;

    logic          clk;
    logic          rst_x;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_data, p1_data;
    logic [MW-1:0] p0_mask, p1_mask;
    logic          p0_ack, p1_ack;
    logic [DW-1:0] rdata;
    logic          mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_mask;
    logic          mem_ready, mem_calib, mem_dv;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    dram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
        .clk(clk), .rst_x(rst_x),
        .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_data(p0_data), .i_p0_mask(p0_mask),
        .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_data(p1_data), .i_p1_mask(p1_mask),
        .o_p0_ack(p0_ack), .o_p1_ack(p1_ack), .o_rdata(rdata),
        .o_mem_rd_en(mem_rd_en), .o_mem_wr_en(mem_wr_en),
        .o_mem_addr(mem_addr), .o_mem_data(mem_wdata), .o_mem_mask(mem_mask),
        .i_mem_ready(mem_ready), .i_mem_calib(mem_calib),
        .i_mem_data(mem_rdata), .i_mem_data_valid(mem_dv),
        .o_busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_pattern(input logic [AW-1:0] a);
        logic [DW-1:0] base;
        base = {4{32'hDEADBEEF}};
        return base ^ DW'(a);
    endfunction

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } cmd_t;

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
    } ack_t;

    cmd_t exp_cmd[$];
    ack_t exp_ack[$];

    task automatic expect_txn(input logic port, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input logic [MW-1:0] mask, input bit with_ack);
        cmd_t c;
        ack_t a;
        c.we = we; c.addr = addr; c.data = data; c.mask = mask;
        exp_cmd.push_back(c);
        if (with_ack) begin
            a.port = port; a.we = we; a.addr = addr;
            exp_ack.push_back(a);
        end
    endtask

    // Controller model
    int rd_lat   = 4;
    int wr_lat   = 3;
    int rd_extra = 0;

    initial begin
        logic          is_rd;
        logic [AW-1:0] a;
        bit            aborted;
        mem_ready = 1'b1;
        mem_dv    = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_x && (mem_rd_en || mem_wr_en)) begin
                is_rd = mem_rd_en;
                a     = mem_addr;
                @(posedge clk); #1 mem_ready = 1'b0;
                aborted = 1'b0;
                for (int k = 0; k < (is_rd ? rd_lat : wr_lat); k++) begin
                    @(posedge clk); #1;
                    if (!rst_x) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (aborted || !is_rd) begin
                    mem_ready = 1'b1;
                end else begin
                    mem_dv    = 1'b1;
                    mem_rdata = rd_pattern(a);
                    @(posedge clk); #1 mem_dv = 1'b0;
                    for (int k = 0; k < rd_extra; k++) begin
                        @(posedge clk); #1;
                    end
                    mem_ready = 1'b1;
                end
            end
        end
    end

    // Edge samples of controller inputs, used to check grant and ack timing
    logic rdy_e = 1'b1, rdy_prev_e = 1'b1, cal_e = 1'b0, dv_e = 1'b0;
    always @(posedge clk) begin
        rdy_prev_e <= rdy_e;
        rdy_e      <= mem_ready;
        cal_e      <= mem_calib;
        dv_e       <= mem_dv;
    end

    // Monitor / scoreboard
    int   n_pulses = 0;
    int   ack_cnt0 = 0;
    int   ack_cnt1 = 0;
    logic inflight = 1'b0;
    logic en_prev  = 1'b0;

    always @(negedge clk) begin
        cmd_t c;
        ack_t a;
        if (!rst_x) begin
            inflight = 1'b0;
            en_prev  = 1'b0;
        end else begin
            if (mem_rd_en || mem_wr_en) begin
                check("single_enable", DW'(mem_rd_en & mem_wr_en), '0);
                check("pulse_width", DW'(en_prev), '0);
                check("no_overlap", DW'(inflight), '0);
                check("grant_ready", DW'(rdy_e), DW'(1));
                check("grant_calib", DW'(cal_e), DW'(1));
                if (exp_cmd.size() == 0) begin
                    check("cmd_unexpected", DW'(1), '0);
                end else begin
                    c = exp_cmd.pop_front();
                    check("cmd_we", DW'(mem_wr_en), DW'(c.we));
                    check("cmd_addr", DW'(mem_addr), DW'(c.addr));
                    if (c.we) begin
                        check("cmd_data", mem_wdata, c.data);
                        check("cmd_mask", DW'(mem_mask), DW'(c.mask));
                    end
                end
                inflight = 1'b1;
                n_pulses++;
            end
            en_prev = mem_rd_en || mem_wr_en;
            if (p0_ack || p1_ack) begin
                check("ack_exclusive", DW'(p0_ack & p1_ack), '0);
                if (exp_ack.size() == 0) begin
                    check("ack_unexpected", DW'(1), '0);
                end else begin
                    a = exp_ack.pop_front();
                    check("ack_port", DW'(p1_ack), DW'(a.port));
                    if (a.we) begin
                        check("wr_ack_timing", DW'({rdy_prev_e, rdy_e}), DW'(2'b01));
                    end else begin
                        check("rd_ack_timing", DW'(dv_e), DW'(1));
                        check("rdata", rdata, rd_pattern(a.addr));
                    end
                end
                if (p0_ack) ack_cnt0++;
                if (p1_ack) ack_cnt1++;
                inflight = 1'b0;
            end
        end
    end

    task automatic do_req(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [MW-1:0] mask, input bit hold);
        bit got;
        bit aborted;
        if (port) begin
            p1_we = we; p1_addr = addr; p1_data = data; p1_mask = mask; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_addr = addr; p0_data = data; p0_mask = mask; p0_req = 1'b1;
        end
        got = 1'b0;
        aborted = 1'b0;
        for (int c = 0; c < 1000 && !got && !aborted; c++) begin
            @(negedge clk);
            if (!rst_x) aborted = 1'b1;
            else if (port ? p1_ack : p0_ack) got = 1'b1;
        end
        if (!aborted) check("ack_received", DW'(got), DW'(1));
        if (!hold || aborted) begin
            if (port) p1_req = 1'b0;
            else p0_req = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int a0;
        rst_x = 1'b0; mem_calib = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_data = '0; p0_mask = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_data = '0; p1_mask = '0;
        #12;
        check("rst_busy", DW'(busy), '0);
        check("rst_enables", DW'({mem_rd_en, mem_wr_en, p0_ack, p1_ack}), '0);
        check("rst_rdata", rdata, '0);
        check("rst_mem_fields", DW'({mem_addr, mem_mask}) | mem_wdata, '0);
        @(negedge clk);
        rst_x = 1'b1;

        // Calibration gate
        expect_txn(1'b0, 1'b0, 27'h0000555, '0, '0, 1'b1);
        base = n_pulses;
        fork
            do_req(1'b0, 1'b0, 27'h0000555, '0, '0, 1'b0);
            begin
                repeat (50) @(negedge clk);
                check("calib_gate_pulses", DW'(n_pulses - base), '0);
                check("calib_gate_busy", DW'(busy), '0);
                mem_calib = 1'b1;
            end
        join
        repeat (2) @(negedge clk);

        // Single read, 10-cycle controller latency
        rd_lat = 10;
        expect_txn(1'b0, 1'b0, 27'h0000040, '0, '0, 1'b1);
        do_req(1'b0, 1'b0, 27'h0000040, '0, '0, 1'b0);
        rd_lat = 4;
        repeat (2) @(negedge clk);

        // Single write from port 1
        expect_txn(1'b1, 1'b1, 27'h0000123, {16{8'hA5}}, 16'h00FF, 1'b1);
        do_req(1'b1, 1'b1, 27'h0000123, {16{8'hA5}}, 16'h00FF, 1'b0);
        repeat (2) @(negedge clk);

        // Contention: both ports continuously, grants must alternate starting at port 0
        expect_txn(1'b0, 1'b0, 27'h0000100, '0, '0, 1'b1);
        expect_txn(1'b1, 1'b1, 27'h0000200, {4{32'h11112222}}, 16'hF00F, 1'b1);
        expect_txn(1'b0, 1'b1, 27'h0000101, {4{32'h33334444}}, 16'h0000, 1'b1);
        expect_txn(1'b1, 1'b0, 27'h0000201, '0, '0, 1'b1);
        expect_txn(1'b0, 1'b0, 27'h0000102, '0, '0, 1'b1);
        expect_txn(1'b1, 1'b1, 27'h0000202, {4{32'h55556666}}, 16'hAAAA, 1'b1);
        fork
            begin
                do_req(1'b0, 1'b0, 27'h0000100, '0, '0, 1'b0);
                do_req(1'b0, 1'b1, 27'h0000101, {4{32'h33334444}}, 16'h0000, 1'b0);
                do_req(1'b0, 1'b0, 27'h0000102, '0, '0, 1'b0);
            end
            begin
                do_req(1'b1, 1'b1, 27'h0000200, {4{32'h11112222}}, 16'hF00F, 1'b0);
                do_req(1'b1, 1'b0, 27'h0000201, '0, '0, 1'b0);
                do_req(1'b1, 1'b1, 27'h0000202, {4{32'h55556666}}, 16'hAAAA, 1'b0);
            end
        join
        repeat (2) @(negedge clk);

        // Back-to-back on port 0 with req held through the ack; ready returns late
        rd_extra = 3;
        a0 = ack_cnt0;
        expect_txn(1'b0, 1'b0, 27'h0000300, '0, '0, 1'b1);
        expect_txn(1'b0, 1'b1, 27'h0000301, {4{32'h77778888}}, 16'h0F0F, 1'b1);
        do_req(1'b0, 1'b0, 27'h0000300, '0, '0, 1'b1);
        do_req(1'b0, 1'b1, 27'h0000301, {4{32'h77778888}}, 16'h0F0F, 1'b0);
        repeat (6) @(negedge clk);
        check("b2b_ack_count", DW'(ack_cnt0 - a0), DW'(2));
        rd_extra = 0;

        // Reset in the middle of a read
        rd_lat = 40;
        expect_txn(1'b0, 1'b0, 27'h0000400, '0, '0, 1'b0);
        a0 = ack_cnt0;
        fork
            do_req(1'b0, 1'b0, 27'h0000400, '0, '0, 1'b0);
            begin
                repeat (8) @(negedge clk);
                check("midrd_busy", DW'(busy), DW'(1));
                #3 rst_x = 1'b0;
                #1;
                check("midrd_rst_busy", DW'(busy), '0);
                check("midrd_rst_enables", DW'({mem_rd_en, mem_wr_en, p0_ack, p1_ack}), '0);
                check("midrd_rst_rdata", rdata, '0);
                check("midrd_rst_fields", DW'({mem_addr, mem_mask}) | mem_wdata, '0);
            end
        join
        repeat (3) @(negedge clk);
        rst_x = 1'b1;
        rd_lat = 4;
        repeat (3) @(negedge clk);
        check("midrd_no_ack", DW'(ack_cnt0 - a0), '0);

        // After reset port 0 wins first even though port 0 was granted last
        expect_txn(1'b0, 1'b0, 27'h0000500, '0, '0, 1'b1);
        expect_txn(1'b1, 1'b1, 27'h0000600, {4{32'h9999AAAA}}, 16'h3C3C, 1'b1);
        fork
            do_req(1'b0, 1'b0, 27'h0000500, '0, '0, 1'b0);
            do_req(1'b1, 1'b1, 27'h0000600, {4{32'h9999AAAA}}, 16'h3C3C, 1'b0);
        join
        repeat (4) @(negedge clk);
        check("cmd_queue_drained", DW'(exp_cmd.size()), '0);
        check("ack_queue_drained", DW'(exp_ack.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
